// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads always win, pixel writes are
// queued in a small FIFO and drained into RAM on cycles without a read.
module vga_fb_arbiter #(
   parameter int unsigned AW         = 15,
   parameter int unsigned DW         = 8,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned WF_DEPTH   = 8,
   parameter int unsigned BLANK_ONLY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   input  logic          disp_blank,
   output logic          disp_rvalid,
   output logic [DW-1:0] disp_rdata,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wf_empty,
   output logic [15:0]   wr_defer,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned PW       = $clog2(WF_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(WF_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} arb_state_t;

   arb_state_t       state, next_state;
   logic [AW+DW-1:0] fifo_mem [WF_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic             push, pop, rd_tap;
   logic [AW-1:0]    head_addr;
   logic [DW-1:0]    head_data;

   assign {head_addr, head_data} = fifo_mem[rd_ptr];
   assign wr_ready = (count != FULL_CNT);
   assign push     = wr_valid & wr_ready;
   assign pop      = (next_state == ST_WR);
   // The registered state is the RAM command currently on the bus.
   assign mem_en   = (state != ST_IDLE);
   assign mem_we   = (state == ST_WR);
   assign wf_empty = (count == '0) && !mem_we;

   always_comb begin
      next_state = ST_IDLE;
      if (disp_req)
         next_state = ST_RD;
      else if (count != '0 && (BLANK_ONLY == 0 || disp_blank))
         next_state = ST_WR;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {wr_addr, wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_defer  <= '0;
      end else begin
         case (next_state)
            ST_RD: mem_addr <= disp_addr;
            ST_WR: begin
               mem_addr  <= head_addr;
               mem_wdata <= head_data;
            end
            default: ;
         endcase
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (count != '0 && next_state != ST_WR && wr_defer != '1)
            wr_defer <= wr_defer + 16'd1;
      end
   end

   // rd_tap marks the cycle in which mem_rdata holds the data of an issued read.
   if (RD_LAT == 1) begin : g_lat1
      assign rd_tap = (state == ST_RD);
   end else begin : g_latn
      logic [RD_LAT-2:0] rd_pipe;
      always_ff @(posedge clk) begin
         if (rst) rd_pipe <= '0;
         else     rd_pipe <= (RD_LAT-1)'({rd_pipe, (state == ST_RD)});
      end
      assign rd_tap = rd_pipe[RD_LAT-2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_rvalid <= 1'b0;
         disp_rdata  <= '0;
      end else begin
         disp_rvalid <= rd_tap;
         if (rd_tap) disp_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a default instance plus a BLANK_ONLY=1
// instance, both driven from the same stimulus.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_req, disp_blank, wr_valid;
   logic [14:0] disp_addr, wr_addr;
   logic [7:0]  wr_data;

   logic        disp_rvalid, wr_ready, wf_empty, mem_en, mem_we;
   logic [7:0]  disp_rdata, mem_wdata, mem_rdata;
   logic [15:0] wr_defer;
   logic [14:0] mem_addr;

   logic        b_disp_rvalid, b_wr_ready, b_wf_empty, b_mem_en, b_mem_we;
   logic [7:0]  b_disp_rdata, b_mem_wdata, b_mem_rdata;
   logic [15:0] b_wr_defer;
   logic [14:0] b_mem_addr;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int we_base;

   always #5 clk = ~clk;

   // RAM model: pixel at address a reads as a[7:0] ^ a[14:7]
   assign mem_rdata   = mem_addr[7:0] ^ mem_addr[14:7];
   assign b_mem_rdata = b_mem_addr[7:0] ^ b_mem_addr[14:7];

   always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

   vga_fb_arbiter dut (
      .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_blank(disp_blank), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wf_empty(wf_empty), .wr_defer(wr_defer), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   vga_fb_arbiter #(.BLANK_ONLY(1)) dut_b (
      .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_blank(disp_blank), .disp_rvalid(b_disp_rvalid), .disp_rdata(b_disp_rdata),
      .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wf_empty(b_wf_empty), .wr_defer(b_wr_defer), .mem_en(b_mem_en), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // T1: reset with active stimulus
      rst = 1'b1; disp_req = 1'b1; disp_addr = 15'h0007; disp_blank = 1'b1;
      wr_valid = 1'b1; wr_addr = 15'h0055; wr_data = 8'h66;
      repeat (3) tick();
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_rvalid", 32'(disp_rvalid), 0);
      chk("rst_rdata", 32'(disp_rdata), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_wf_empty", 32'(wf_empty), 1);
      chk("rst_wr_defer", 32'(wr_defer), 0);
      rst = 1'b0; disp_req = 1'b0; wr_valid = 1'b0; disp_blank = 1'b0;
      tick();

      // T2: read latency and back-to-back reads
      disp_req = 1'b1; disp_addr = 15'h0123;
      tick();
      chk("rd_mem_en", 32'(mem_en), 1);
      chk("rd_mem_we", 32'(mem_we), 0);
      chk("rd_mem_addr0", 32'(mem_addr), 32'h0123);
      chk("rd_rvalid_early", 32'(disp_rvalid), 0);
      disp_addr = 15'h4ABC;
      tick();
      chk("rd_mem_addr1", 32'(mem_addr), 32'h4ABC);
      chk("rd_rvalid0", 32'(disp_rvalid), 1);
      chk("rd_rdata0", 32'(disp_rdata), 32'h21);
      disp_addr = 15'h7F00;
      tick();
      chk("rd_mem_addr2", 32'(mem_addr), 32'h7F00);
      chk("rd_rvalid1", 32'(disp_rvalid), 1);
      chk("rd_rdata1", 32'(disp_rdata), 32'h29);
      disp_req = 1'b0;
      tick();
      chk("rd_rvalid2", 32'(disp_rvalid), 1);
      chk("rd_rdata2", 32'(disp_rdata), 32'hFE);
      chk("rd_mem_en_off", 32'(mem_en), 0);
      tick();
      chk("rd_rvalid_off", 32'(disp_rvalid), 0);

      // T3: fill FIFO under continuous scanout
      disp_req = 1'b1; disp_addr = 15'h0010; wr_valid = 1'b1;
      we_base = we_cnt;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 15'h1000 + 15'(i);
         wr_data = 8'hA0 + 8'(i);
         chk("fill_wr_ready", 32'(wr_ready), 1);
         chk("fill_wr_defer", 32'(wr_defer), (i == 0) ? 0 : i - 1);
         chk("fill_mem_we", 32'(mem_we), 0);
         tick();
      end
      wr_addr = 15'h1008; wr_data = 8'hA8;
      chk("full_wr_ready", 32'(wr_ready), 0);
      chk("full_wr_defer", 32'(wr_defer), 7);
      tick();
      chk("full_wr_ready2", 32'(wr_ready), 0);
      chk("full_wr_defer2", 32'(wr_defer), 8);
      chk("full_wf_empty", 32'(wf_empty), 0);
      chk("fill_no_writes", 32'(we_cnt - we_base), 0);

      // T4: drain in push order once scanout stops
      disp_req = 1'b0; wr_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         chk("drain_mem_en", 32'(mem_en), 1);
         chk("drain_mem_we", 32'(mem_we), 1);
         chk("drain_mem_addr", 32'(mem_addr), 32'h1000 + j);
         chk("drain_mem_wdata", 32'(mem_wdata), 32'hA0 + j);
      end
      chk("drain_last_wf_empty", 32'(wf_empty), 0);
      tick();
      chk("drain_done_we", 32'(mem_we), 0);
      chk("drain_done_wf_empty", 32'(wf_empty), 1);
      chk("drain_done_wr_ready", 32'(wr_ready), 1);
      chk("drain_done_wr_defer", 32'(wr_defer), 8);

      // T5: BLANK_ONLY instance holds its 8 writes until blanking
      chk("blk_hold_we0", 32'(b_mem_we), 0);
      chk("blk_hold_wf_empty", 32'(b_wf_empty), 0);
      chk("blk_hold_wr_ready", 32'(b_wr_ready), 0);
      tick();
      chk("blk_hold_we1", 32'(b_mem_we), 0);
      disp_blank = 1'b1;
      chk("blk_same_cycle_we", 32'(b_mem_we), 0);
      tick();
      chk("blk_drain_en", 32'(b_mem_en), 1);
      chk("blk_drain_we", 32'(b_mem_we), 1);
      chk("blk_drain_addr", 32'(b_mem_addr), 32'h1000);
      chk("blk_drain_wdata", 32'(b_mem_wdata), 32'hA0);
      disp_blank = 1'b0;
      tick();
      chk("blk_stop_we", 32'(b_mem_we), 0);
      chk("blk_stop_wr_ready", 32'(b_wr_ready), 1);

      // T6: reset with full FIFO and reads in flight
      disp_req = 1'b1; disp_addr = 15'h0200; wr_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wr_addr = 15'h2000 + 15'(k);
         wr_data = 8'(k);
         tick();
      end
      chk("r6_full", 32'(wr_ready), 0);
      chk("r6_rd_inflight", 32'(disp_rvalid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; disp_req = 1'b0; wr_valid = 1'b0;
      chk("r6_rvalid", 32'(disp_rvalid), 0);
      chk("r6_mem_en", 32'(mem_en), 0);
      chk("r6_wr_ready", 32'(wr_ready), 1);
      chk("r6_wf_empty", 32'(wf_empty), 1);
      chk("r6_wr_defer", 32'(wr_defer), 0);
      chk("r6_b_wf_empty", 32'(b_wf_empty), 1);
      we_base = we_cnt;
      repeat (3) begin
         tick();
         chk("r6_post_rvalid", 32'(disp_rvalid), 0);
         chk("r6_post_mem_we", 32'(mem_we), 0);
      end
      chk("r6_no_writes", 32'(we_cnt - we_base), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
